// File: rtl/cordic_pkg.sv
// cordic_pkg: shared types and elaboration-time constants for the iterative
// CORDIC engine (cordic_seq) and its single micro-rotation stage.
//   cordic_mode_e  : CORDIC_ROT (drive z->0) / CORDIC_VEC (drive y->0)
//   cordic_state_e : sequencer states IDLE, RUN, GAIN, DONE
//   cordic_atan()  : round(atan(2^-i) * 2^f), evaluated at elaboration
//   cordic_k_fx()  : round(K * 2^f), K = 0.6072529350 (inverse CORDIC gain)
package cordic_pkg;

  typedef enum logic {
    CORDIC_ROT = 1'b0,
    CORDIC_VEC = 1'b1
  } cordic_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAIN = 2'd2,
    DONE = 2'd3
  } cordic_state_e;

  localparam real K_REAL = 0.6072529350;

  // Only ever called with constant arguments to build localparams.
  function automatic logic [63:0] cordic_atan(input int unsigned i, input int unsigned f);
    real s;
    real a;
    s = 1.0;
    for (int unsigned k = 0; k < i; k++) s = s / 2.0;
    a = $atan(s);
    for (int unsigned k = 0; k < f; k++) a = a * 2.0;
    return 64'(longint'(a));
  endfunction

  function automatic logic [63:0] cordic_k_fx(input int unsigned f);
    real a;
    a = K_REAL;
    for (int unsigned k = 0; k < f; k++) a = a * 2.0;
    return 64'(longint'(a));
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// cordic_stage: one combinational CORDIC micro-rotation.
//   x, y, z            : current signed Q2.F state
//   shift              : stage index i (shift amount for x, y)
//   atan_c             : atan(2^-i) in Q2.F
//   mode               : CORDIC_ROT drives z->0, CORDIC_VEC drives y->0
//   x_next/y_next/z_next : updated state, all adds wrap mod 2^W
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int unsigned W  = 32,
  parameter int unsigned SW = 5
) (
  input  logic signed [W-1:0]  x,
  input  logic signed [W-1:0]  y,
  input  logic signed [W-1:0]  z,
  input  logic        [SW-1:0] shift,
  input  logic signed [W-1:0]  atan_c,
  input  cordic_mode_e         mode,
  output logic signed [W-1:0]  x_next,
  output logic signed [W-1:0]  y_next,
  output logic signed [W-1:0]  z_next
);

  logic                pos;
  logic signed [W-1:0] xs;
  logic signed [W-1:0] ys;

  always_comb begin
    // d = +1: rotation when z >= 0, vectoring when y < 0
    pos = (mode == CORDIC_VEC) ? y[W-1] : ~z[W-1];
    xs  = x >>> shift;
    ys  = y >>> shift;
    if (pos) begin
      x_next = x - ys;
      y_next = y + xs;
      z_next = z - atan_c;
    end else begin
      x_next = x + ys;
      y_next = y - xs;
      z_next = z + atan_c;
    end
  end

endmodule

// File: rtl/cordic_seq.sv
// cordic_seq: iterative CORDIC engine, one micro-rotation per clock through a
// single shared cordic_stage. Rotation or vectoring selected per operation.
// Optional macro CORDIC_GAIN_COMP_EN adds a GAIN state that scales x/y by K.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operand handshake (ready only in IDLE)
//   in_mode               : 0 rotation, 1 vectoring
//   x_in, y_in, z_in      : signed Q2.F operands (z in radians)
//   out_valid/out_ready   : result handshake, result held until accepted
//   x_out, y_out, z_out   : signed Q2.F results
//   busy                  : engine not IDLE
module cordic_seq
  import cordic_pkg::*;
#(
  parameter int unsigned FRAC_BITS  = 30,
  parameter int unsigned ITERATIONS = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [FRAC_BITS+1:0] x_in,
  input  logic [FRAC_BITS+1:0] y_in,
  input  logic [FRAC_BITS+1:0] z_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FRAC_BITS+1:0] x_out,
  output logic [FRAC_BITS+1:0] y_out,
  output logic [FRAC_BITS+1:0] z_out,
  output logic                 busy
);

  localparam int unsigned W  = FRAC_BITS + 2;
  localparam int unsigned IW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam logic [IW-1:0] LAST = IW'(ITERATIONS - 1);

  if (ITERATIONS < 1 || ITERATIONS > FRAC_BITS) begin : g_bad_cfg
    $error("cordic_seq: ITERATIONS must lie in 1..FRAC_BITS");
  end

  // Arctangent table, one elaboration-time constant per stage.
  logic signed [W-1:0] atan_tab [ITERATIONS];
  for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan
    localparam logic signed [W-1:0] ATAN_G = W'(cordic_atan(g, FRAC_BITS));
    assign atan_tab[g] = ATAN_G;
  end

  cordic_state_e       state;
  cordic_state_e       state_n;
  logic [IW-1:0]       iter;
  cordic_mode_e        mode_r;
  logic signed [W-1:0] x_r;
  logic signed [W-1:0] y_r;
  logic signed [W-1:0] z_r;
  logic signed [W-1:0] x_s;
  logic signed [W-1:0] y_s;
  logic signed [W-1:0] z_s;
  logic signed [W-1:0] atan_cur;

  assign atan_cur = atan_tab[iter];

  cordic_stage #(
    .W (W),
    .SW(IW)
  ) u_stage (
    .x     (x_r),
    .y     (y_r),
    .z     (z_r),
    .shift (iter),
    .atan_c(atan_cur),
    .mode  (mode_r),
    .x_next(x_s),
    .y_next(y_s),
    .z_next(z_s)
  );

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [W-1:0] K_FX = W'(cordic_k_fx(FRAC_BITS));
  logic signed [2*W-1:0] x_p;
  logic signed [2*W-1:0] y_p;
  logic signed [W-1:0]   x_g;
  logic signed [W-1:0]   y_g;

  always_comb begin
    x_p = (2*W)'(x_r) * (2*W)'(K_FX);
    y_p = (2*W)'(y_r) * (2*W)'(K_FX);
    x_g = W'(x_p >>> FRAC_BITS);
    y_g = W'(y_p >>> FRAC_BITS);
  end
`endif

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_n = RUN;
      end
      RUN: begin
        if (iter == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_n = GAIN;
`else
          state_n = DONE;
`endif
        end
      end
      GAIN: state_n = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Working registers double as the output registers: they only move in
  // IDLE/RUN/GAIN, so they are stable whenever out_valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      iter   <= '0;
      mode_r <= CORDIC_ROT;
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            x_r    <= x_in;
            y_r    <= y_in;
            z_r    <= z_in;
            mode_r <= in_mode ? CORDIC_VEC : CORDIC_ROT;
            iter   <= '0;
          end
        end
        RUN: begin
          x_r  <= x_s;
          y_r  <= y_s;
          z_r  <= z_s;
          iter <= (iter == LAST) ? '0 : iter + 1'b1;
        end
`ifdef CORDIC_GAIN_COMP_EN
        GAIN: begin
          x_r <= x_g;
          y_r <= y_g;
        end
`endif
        default: ;
      endcase
    end
  end

  assign x_out = x_r;
  assign y_out = y_r;
  assign z_out = z_r;

endmodule

// File: tb/tb_cordic_seq.sv
module tb_cordic_seq;

  localparam int F   = 30;
  localparam int IT  = 24;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int  GC    = 1;
  localparam real GAINF = 1.0;
`else
  localparam int  GC    = 0;
  localparam real GAINF = 1.6467602581;
`endif
  localparam int     LAT   = IT + GC;
  localparam real    SCALE = 1073741824.0;
  localparam longint KFX   = longint'(0.6072529350 * SCALE);
  // final-stage angle residual can reach atan(2^-23) ~ 128 LSB
  localparam longint TOL   = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_mode = 1'b0;
  logic [31:0] x_in = '0;
  logic [31:0] y_in = '0;
  logic [31:0] z_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] x_out;
  logic [31:0] y_out;
  logic [31:0] z_out;
  logic        busy;

  int total = 0;
  int bad   = 0;

  cordic_seq #(.FRAC_BITS(F), .ITERATIONS(IT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  function automatic longint wrap32(input longint v);
    logic signed [31:0] t;
    t = v[31:0];
    return longint'(t);
  endfunction

  function automatic real fx(input logic [31:0] v);
    return $itor($signed(v)) / SCALE;
  endfunction

  // Reference: the CORDIC recurrence in 64-bit integers, wrapped to 32 bits.
  task automatic model(input logic md, input logic [31:0] xi, yi, zi,
                       output logic [31:0] xo, yo, zo);
    longint x, y, z, d, nx, ny, at;
    real s;
    x = longint'($signed(xi));
    y = longint'($signed(yi));
    z = longint'($signed(zi));
    for (int i = 0; i < IT; i++) begin
      s = 1.0;
      for (int k = 0; k < i; k++) s = s / 2.0;
      at = longint'($atan(s) * SCALE);
      if (md) d = (y < 0) ? 1 : -1;
      else    d = (z >= 0) ? 1 : -1;
      nx = wrap32(x - d * (y >>> i));
      ny = wrap32(y + d * (x >>> i));
      z  = wrap32(z - d * at);
      x  = nx;
      y  = ny;
    end
    if (GC != 0) begin
      x = wrap32((x * KFX) >>> F);
      y = wrap32((y * KFX) >>> F);
    end
    xo = x[31:0];
    yo = y[31:0];
    zo = z[31:0];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input logic [31:0] obs, input real exp_r);
    longint e, diff;
    e = longint'(exp_r * SCALE);
    diff = longint'($signed(obs)) - e;
    if (diff < 0) diff = -diff;
    total++;
    assert (diff <= TOL) else begin
      bad++;
      $error("FAIL %s observed=%h expected~%h", tag, obs, 32'(e));
    end
  endtask

  // Called at posedge+1 with the engine idle; returns at accept edge+1.
  task automatic start_op(input string tag, input logic md, input logic [31:0] x, y, z);
    in_valid = 1'b1;
    in_mode  = md;
    x_in = x;
    y_in = y;
    z_in = z;
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    x_in = $urandom;
    y_in = $urandom;
    z_in = $urandom;
    in_mode = ~md;
  endtask

  task automatic wait_out(input string tag);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(LAT));
  endtask

  task automatic chk_result(input string tag, input logic md, input logic [31:0] x, y, z);
    logic [31:0] ex, ey, ez;
    model(md, x, y, z, ex, ey, ez);
    chk({tag, "_x"}, x_out, ex);
    chk({tag, "_y"}, y_out, ey);
    chk({tag, "_z"}, z_out, ez);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_idle_ready"}, {31'b0, in_ready}, 32'd1);
    chk({tag, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic md, input logic [31:0] x, y, z);
    start_op(tag, md, x, y, z);
    wait_out(tag);
    chk_result(tag, md, x, y, z);
    release_out(tag);
  endtask

  function automatic logic [31:0] rnd_fx(input int unsigned lim);
    int v;
    v = int'($urandom_range(0, lim));
    if ($urandom_range(0, 1) == 1) v = -v;
    return 32'(v);
  endfunction

  initial begin
    logic [31:0] hx, hy, hz, rx, ry, rz;
    logic [31:0] bx[4], by[4], bz[4];
    logic        bm[4];
    int seen, k, nres, lastacc;
    logic acc, hs;

    // reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_x", x_out, 32'd0);
    chk("rst_y", y_out, 32'd0);
    chk("rst_z", z_out, 32'd0);

    // 1: rotation by pi/6 starting from x=K
    start_op("rot30", 1'b0, 32'h26DD3B6A, 32'h0, 32'h2182A470);
    chk("rot30_busy", {31'b0, busy}, 32'd1);
    wait_out("rot30");
    chk_result("rot30", 1'b0, 32'h26DD3B6A, 32'h0, 32'h2182A470);
    chk_near("rot30_cos", x_out, GAINF * fx(32'h26DD3B6A) * $cos(fx(32'h2182A470)));
    chk_near("rot30_sin", y_out, GAINF * fx(32'h26DD3B6A) * $sin(fx(32'h2182A470)));
    chk_near("rot30_z0", z_out, 0.0);
    release_out("rot30");

    // 2: vectoring of (0.5, 0.5)
    start_op("vec45", 1'b1, 32'h20000000, 32'h20000000, 32'h0);
    wait_out("vec45");
    chk_result("vec45", 1'b1, 32'h20000000, 32'h20000000, 32'h0);
    chk_near("vec45_mag", x_out, GAINF * $sqrt(0.5));
    chk_near("vec45_y0", y_out, 0.0);
    chk_near("vec45_ang", z_out, $atan2(0.5, 0.5));
    release_out("vec45");

    // 3: backpressure, with in_valid asserted while the result waits
    start_op("bp", 1'b0, 32'h1F000000, 32'hF0000000, 32'hE0000000);
    wait_out("bp");
    hx = x_out; hy = y_out; hz = z_out;
    chk_result("bp", 1'b0, 32'h1F000000, 32'hF0000000, 32'hE0000000);
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_hold_x", x_out, hx);
      chk("bp_hold_y", y_out, hy);
      chk("bp_hold_z", z_out, hz);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    release_out("bp");

    // 4: reset in RUN at iteration 5
    start_op("abort", 1'b0, 32'h26DD3B6A, 32'h0, 32'h10000000);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_x", x_out, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_output", 32'(seen), 32'd0);
    run_op("after_abort", 1'b1, 32'h30000000, 32'hE8000000, 32'h01000000);

    // 6: rotation by -pi/2
    start_op("rotm90", 1'b0, 32'h26DD3B6A, 32'h0, 32'h9B7812AF);
    wait_out("rotm90");
    chk_result("rotm90", 1'b0, 32'h26DD3B6A, 32'h0, 32'h9B7812AF);
    chk_near("rotm90_x", x_out, 0.0);
    chk_near("rotm90_y", y_out, -GAINF * fx(32'h26DD3B6A));
    release_out("rotm90");

    // 5: back-to-back with in_valid held high and out_ready high
    for (int i = 0; i < 4; i++) begin
      bm[i] = 1'($urandom_range(0, 1));
      bx[i] = rnd_fx(32'd644245094);
      by[i] = rnd_fx(32'd644245094);
      bz[i] = rnd_fx(bm[i] ? 32'd300000000 : 32'd1600000000);
    end
    out_ready = 1'b1;
    k = 0; nres = 0; lastacc = -1;
    for (int cyc = 0; cyc < 400 && nres < 4; cyc++) begin
      if (k < 4) begin
        in_valid = 1'b1;
        in_mode  = bm[k];
        x_in = bx[k]; y_in = by[k]; z_in = bz[k];
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (hs) begin
        chk_result("b2b", bm[nres], bx[nres], by[nres], bz[nres]);
        nres++;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (k > 0) chk("b2b_period", 32'(cyc - lastacc), 32'(LAT + 2));
        lastacc = cyc;
        k++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_count", 32'(nres), 32'd4);
    @(posedge clk); #1;

    // randomized operands in both modes
    for (int r = 0; r < 8; r++) begin
      logic md;
      md = 1'($urandom_range(0, 1));
      rx = rnd_fx(32'd644245094);
      ry = rnd_fx(32'd644245094);
      rz = rnd_fx(md ? 32'd300000000 : 32'd1600000000);
      run_op("rand", md, rx, ry, rz);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
